// File: rtl/cvm300_frame_sequencer.sv
// rtl/cvm300_frame_sequencer.sv - CVM300 capture sequencer: FIFO reset, settle, FRAME_REQ pulse, readout tracking (optional CVM_LINE_COUNT_EN line counter)
module cvm300_frame_sequencer #(
    parameter int FIFO_RST_CYCLES  = 4,
    parameter int SETTLE_CYCLES    = 16,
    parameter int REQ_PULSE_CYCLES = 1,
    parameter int FRAME_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES   = 300000,
    parameter int TIMEOUT_W        = 24
) (
    input  logic                   FSM_Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   data_valid,
    input  logic                   fifo_prog_full,
    output logic                   frame_req,
    output logic                   fifo_wr_rst,
    output logic                   fifo_rd_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [FRAME_CNT_W-1:0] frames_done,
    output logic [2:0]             state
`ifdef CVM_LINE_COUNT_EN
    ,
    output logic [15:0]            line_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FIFO_RST   = 3'd1,
        S_SETTLE     = 3'd2,
        S_REQ        = 3'd3,
        S_WAIT_VALID = 3'd4,
        S_READOUT    = 3'd5,
        S_GAP        = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    // One shared dwell counter serves every timed state; it is sized by
    // TIMEOUT_W, which must therefore also hold the reset/settle/pulse lengths.
    localparam logic [TIMEOUT_W-1:0] FIFO_LAST    = TIMEOUT_W'(FIFO_RST_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST  = TIMEOUT_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] REQ_LAST     = TIMEOUT_W'(REQ_PULSE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 cur;
    state_t                 nxt;
    logic [TIMEOUT_W-1:0]   cnt;
    logic                   start_q;
    logic                   dv_q;
    logic                   cont_q;
    logic [FRAME_CNT_W-1:0] target_q;
    logic [FRAME_CNT_W-1:0] frames_inc;
    logic                   launch;
    logic                   frame_end;
    logic                   timeout_hit;
    logic                   timed_state;

    assign state       = cur;
    assign frames_inc  = frames_done + FRAME_CNT_W'(1);
    assign timed_state = (cur == S_FIFO_RST) || (cur == S_SETTLE) ||
                         (cur == S_REQ) || (cur == S_WAIT_VALID);

    // State register
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state decode plus single-cycle event strobes; abort overrides everything
    always_comb begin
        nxt         = cur;
        launch      = 1'b0;
        frame_end   = 1'b0;
        timeout_hit = 1'b0;
        case (cur)
            S_IDLE: begin
                if (start && !start_q) begin
                    nxt    = S_FIFO_RST;
                    launch = 1'b1;
                end
            end
            S_FIFO_RST:   if (cnt == FIFO_LAST)   nxt = S_SETTLE;
            S_SETTLE:     if (cnt == SETTLE_LAST) nxt = S_REQ;
            S_REQ:        if (cnt == REQ_LAST)    nxt = S_WAIT_VALID;
            S_WAIT_VALID: begin
                if (data_valid) begin
                    nxt = S_READOUT;
                end else if (cnt == TIMEOUT_LAST) begin
                    nxt         = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_READOUT: begin
                if (dv_q && !data_valid) begin
                    frame_end = 1'b1;
                    if (!cont_q && (frames_inc == target_q)) nxt = S_DONE;
                    else                                      nxt = S_GAP;
                end
            end
            S_GAP:        if (!fifo_prog_full) nxt = S_REQ;
            S_DONE:       nxt = S_IDLE;
            default:      nxt = S_IDLE;
        endcase
        if (abort) begin
            nxt         = S_IDLE;
            launch      = 1'b0;
            frame_end   = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // Dwell counter restarts on every state change and only runs in timed states
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (nxt != cur) begin
            cnt <= '0;
        end else if (timed_state) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

    // Input history; start_q resets high so a start held through reset is not an edge
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_q <= 1'b1;
            dv_q    <= 1'b0;
        end else begin
            start_q <= start;
            dv_q    <= data_valid;
        end
    end

    // Burst configuration captured at launch; a zero frame count means one frame
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cont_q   <= 1'b0;
            target_q <= '0;
        end else if (launch) begin
            cont_q   <= continuous;
            target_q <= (num_frames == '0) ? FRAME_CNT_W'(1) : num_frames;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state register
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_req   <= 1'b0;
            fifo_wr_rst <= 1'b0;
            fifo_rd_rst <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_req   <= (nxt == S_REQ);
            fifo_wr_rst <= (nxt == S_FIFO_RST);
            fifo_rd_rst <= (nxt == S_FIFO_RST);
            busy        <= (nxt != S_IDLE);
            done        <= (nxt == S_DONE);
        end
    end

    // Frame counter and sticky timeout flag, both cleared on launch
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frames_done <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (launch)         frames_done <= '0;
            else if (frame_end) frames_done <= frames_inc;
            if (launch)           timeout_err <= 1'b0;
            else if (timeout_hit) timeout_err <= 1'b1;
        end
    end

`ifdef CVM_LINE_COUNT_EN
    // Line counter: rising data_valid edges within a frame, cleared when a request starts
    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            line_count <= '0;
        end else if (nxt == S_REQ && cur != S_REQ) begin
            line_count <= '0;
        end else if (nxt == S_READOUT && data_valid &&
                     (cur == S_WAIT_VALID || !dv_q) && line_count != 16'hFFFF) begin
            line_count <= line_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cvm300_frame_sequencer.sv
// tb/tb_cvm300_frame_sequencer.sv - directed self-checking bench for cvm300_frame_sequencer
module tb_cvm300_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] num_frames = 8'd0;
    logic       data_valid = 1'b0;
    logic       fifo_prog_full = 1'b0;
    logic       frame_req;
    logic       fifo_wr_rst;
    logic       fifo_rd_rst;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] frames_done;
    logic [2:0] state;
`ifdef CVM_LINE_COUNT_EN
    logic [15:0] line_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int req_rises = 0;
    int done_pulses = 0;
    logic req_q = 1'b0;

    cvm300_frame_sequencer #(
        .FIFO_RST_CYCLES (4),
        .SETTLE_CYCLES   (16),
        .REQ_PULSE_CYCLES(1),
        .FRAME_CNT_W     (8),
        .TIMEOUT_CYCLES  (100),
        .TIMEOUT_W       (24)
    ) dut (
        .FSM_Clk       (clk),
        .Reset_n       (rst_n),
        .start         (start),
        .abort         (abort),
        .continuous    (continuous),
        .num_frames    (num_frames),
        .data_valid    (data_valid),
        .fifo_prog_full(fifo_prog_full),
        .frame_req     (frame_req),
        .fifo_wr_rst   (fifo_wr_rst),
        .fifo_rd_rst   (fifo_rd_rst),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .frames_done   (frames_done),
        .state         (state)
`ifdef CVM_LINE_COUNT_EN
        ,
        .line_count    (line_count)
`endif
    );

    always #5 clk = ~clk;

    // Event monitor: frame_req rising edges and done-high cycles
    always @(posedge clk) begin
        req_q <= frame_req;
        if (frame_req && !req_q) req_rises <= req_rises + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!frame_req && n < 300) begin
            tick;
            n++;
        end
        chk(tag, {31'd0, frame_req}, 32'd1);
    endtask

    // Sensor model: called with frame_req high; 2 idle cycles, then 8 cycles of data_valid
    task automatic serve_frame;
        tick;
        tick;
        tick;
        data_valid = 1'b1;
        repeat (8) tick;
        data_valid = 1'b0;
        tick;
    endtask

    int n;
    int req_base;
    int done_base;

    initial begin
        // Reset with start held high: outputs zero, and release must not launch
        start = 1'b1;
        repeat (3) tick;
        chk("reset_state", state, 0);
        chk("reset_outputs", {frame_req, fifo_wr_rst, fifo_rd_rst, busy, done, timeout_err},
            6'b0);
        chk("reset_frames_done", frames_done, 0);
        rst_n = 1'b1;
        repeat (3) tick;
        chk("start_held_no_edge", {busy, state}, 4'd0);
        start = 1'b0;
        tick;

        // Two-frame burst with full timing
        num_frames = 8'd2;
        req_base   = req_rises;
        done_base  = done_pulses;
        launch;
        chk("burst_fifo_rst_enter", {state, fifo_wr_rst, fifo_rd_rst, busy}, {3'd1, 3'b111});
        repeat (3) tick;
        chk("burst_fifo_rst_last", {fifo_wr_rst, fifo_rd_rst}, 2'b11);
        tick;
        chk("burst_settle_enter", {state, fifo_wr_rst, fifo_rd_rst}, {3'd2, 2'b00});
        wait_req("burst_req1_seen", n);
        chk("burst_req1_latency", n + 5, 21);
        chk("burst_req1_state", state, 3);
        serve_frame;
        chk("burst_f1_frames", frames_done, 1);
        chk("burst_f1_gap", state, 6);
        wait_req("burst_req2_seen", n);
        chk("burst_req2_gap_cycles", n, 1);
        serve_frame;
        chk("burst_f2_frames", frames_done, 2);
        chk("burst_done_pulse", {done, state}, {1'b1, 3'd7});
        tick;
        chk("burst_idle_after", {done, busy, state}, 5'd0);
        tick;
        chk("burst_req_count", req_rises - req_base, 2);
        chk("burst_done_count", done_pulses - done_base, 1);

        // num_frames = 0 behaves as a single frame
        num_frames = 8'd0;
        req_base   = req_rises;
        done_base  = done_pulses;
        launch;
        chk("zero_frames_cleared", frames_done, 0);
        wait_req("zero_req_seen", n);
        chk("zero_req_latency", n + 1, 21);
        serve_frame;
        chk("zero_frames_done", frames_done, 1);
        chk("zero_done", done, 1);
        repeat (5) tick;
        chk("zero_req_count", req_rises - req_base, 1);
        chk("zero_done_count", done_pulses - done_base, 1);

        // FIFO back-pressure holds the second request until prog_full drops
        num_frames = 8'd2;
        launch;
        wait_req("bp_req1_seen", n);
        fifo_prog_full = 1'b1;
        serve_frame;
        chk("bp_gap", {state, frame_req}, {3'd6, 1'b0});
        repeat (48) tick;
        chk("bp_still_blocked", {state, frame_req}, {3'd6, 1'b0});
        fifo_prog_full = 1'b0;
        tick;
        chk("bp_req2_one_cycle", {frame_req, state}, {1'b1, 3'd3});
        chk("bp_no_fifo_reset", {fifo_wr_rst, fifo_rd_rst}, 2'b00);
        serve_frame;
        chk("bp_done", {done, frames_done}, {1'b1, 8'd2});
        tick;

        // No data after a request: timeout after 100 cycles, no done
        num_frames = 8'd1;
        done_base  = done_pulses;
        launch;
        wait_req("to_req_seen", n);
        tick;
        chk("to_wait_state", {frame_req, state}, {1'b0, 3'd4});
        n = 0;
        while (!timeout_err && n < 300) begin
            tick;
            n++;
        end
        chk("to_cycles", n, 100);
        chk("to_idle", {busy, state}, 4'd0);
        repeat (3) tick;
        chk("to_sticky", timeout_err, 1);
        chk("to_no_done", done_pulses - done_base, 0);

        // Continuous capture, aborted in WAIT_VALID after three frames
        continuous = 1'b1;
        num_frames = 8'd1;
        done_base  = done_pulses;
        launch;
        chk("cont_timeout_cleared", timeout_err, 0);
        for (int f = 0; f < 3; f++) begin
            wait_req("cont_req_seen", n);
            serve_frame;
        end
        chk("cont_frames3_gap", {frames_done, state}, {8'd3, 3'd6});
        wait_req("cont_req4_seen", n);
        tick;
        chk("cont_wait_valid", state, 4);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_outputs", {frame_req, busy, state}, 5'd0);
        chk("abort_frames_done", frames_done, 3);
        chk("abort_no_done", done_pulses - done_base, 0);
        continuous = 1'b0;

        // Abort beats start in the same cycle; start left high is not a new edge
        start = 1'b1;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_beats_start", {busy, state}, 4'd0);
        repeat (2) tick;
        chk("start_level_no_edge", {busy, state}, 4'd0);
        start = 1'b0;
        tick;

        // Asynchronous reset in the middle of READOUT
        num_frames = 8'd2;
        launch;
        wait_req("rst_req_seen", n);
        tick;
        tick;
        data_valid = 1'b1;
        repeat (3) tick;
        chk("rst_in_readout", state, 5);
        rst_n = 1'b0;
        #1;
        chk("rst_async_state", state, 0);
        chk("rst_async_outputs", {frame_req, fifo_wr_rst, fifo_rd_rst, busy, done, timeout_err},
            6'b0);
        chk("rst_async_frames", frames_done, 0);
        tick;
        rst_n = 1'b1;
        data_valid = 1'b0;
        repeat (5) tick;
        chk("rst_stays_idle", {busy, state}, 4'd0);
        launch;
        chk("rst_relaunch", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
